mult_axi_master: RTL and testbench
==================================

// Module: mult_axi_master
// PURPOSE
//  AXI4-Lite master that drives the multiplier slave directly downstream. Takes operand pairs
//  from a valid/ready stream and writes A then B. Reads the 64-bit product (low word, then high
//  word) and returns it on a result stream. Sequences one operation at a time.
//  Slave register map: A=+0x0, B=+0x4, RES_LO=+0x8, RES_HI=+0xC, each offset from BASE_ADDR.
// PARAMETERS
//  DATA_WIDTH  32    AXI data width; operands are DATA_WIDTH bits, the product 2*DATA_WIDTH bits
//  ADDR_WIDTH  8     AXI address width
//  BASE_ADDR   0     multiplier base address
//  TIMEOUT     255   maximum wait cycles per phase before abort (1..2^16-1)
// PORTS
//  m2_axi_aclk     in   1             sole clock, rising edge
//  m2_axi_areset   in   1             synchronous reset, active-high
//  op_valid        in   1             operand pair valid
//  op_ready        out  1             operand pair accepted
//  op_a, op_b      in   DATA_WIDTH    multiplicand, multiplier
//  res_valid       out  1             result valid
//  res_ready       in   1             result consumed
//  res_data        out  2*DATA_WIDTH  product {RES_HI,RES_LO}
//  res_err         out  1             1 = slave error response or timeout
//  m2_axi_awaddr/awvalid/awready      ADDR_WIDTH/1/1  write address channel
//  m2_axi_wdata/wstrb/wvalid/wready   DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
//  m2_axi_bresp/bvalid/bready         1/1/1  write response channel; bresp!=0 means error
//  m2_axi_araddr/arvalid/arready      ADDR_WIDTH/1/1  read address channel
//  m2_axi_rdata/rresp/rvalid/rready   DATA_WIDTH/1/1/1  read data channel; rresp!=0 means error
// BEHAVIOUR
//  Reset (also when asserted mid-operation):
//   - state=IDLE; every valid/ready output=0; res_data=0; res_err=0.
//   - awaddr/araddr/wdata=0; wstrb=all ones.
//   - Any in-flight operation is discarded.
//  States: IDLE -> WR_A -> WR_B -> RD_LO -> RD_HI -> DONE -> IDLE.
//  IDLE:
//   - op_ready=1.
//   - On op_valid&op_ready, latch op_a and op_b, then enter WR_A.
//  WR_x:
//   - Assert awvalid and wvalid together on entry; wstrb is all ones.
//   - Each valid drops the cycle after its own handshake. AW and W may complete in either order.
//   - Once both are accepted: bready=1; on bvalid, drop bready.
//   - bresp!=0 -> DONE with err, else next state.
//  RD_x:
//   - Assert arvalid and drop it after the arready handshake; then rready=1.
//   - On rvalid, capture rdata into the LO or HI half of res_data.
//   - rresp!=0 -> DONE with err.
//  DONE:
//   - res_valid=1; hold res_data and res_err stable until res_ready.
//   - Then res_valid=0; enter IDLE; res_err clears on the next operation.
//  Timeout:
//   - A per-state wait counter resets on state entry and counts every cycle the state has not completed.
//   - On reaching TIMEOUT: deassert all AXI valids/readies, go to DONE with res_err=1 and res_data=0.
//  Error abort also forces res_data=0.
//  Latency, slave ready same cycle and responding next cycle: op handshake at cycle 0 -> res_valid at cycle 9.
//  Back-to-back operations: op_ready returns 1 the cycle after the res_valid&res_ready handshake.
//  Never asserts awvalid and arvalid in the same cycle; at most one transaction outstanding.
//  Address = BASE_ADDR + offset, truncated to ADDR_WIDTH.
// TESTING
//  1. op_a=0x278, op_b=0x1468, zero-wait slave model -> writes at 0x0 and 0x4, reads at 0x8 and 0xC;
//     res_data=0x00000000003260C0, res_err=0, 9-cycle latency.
//  2. op_a=op_b=0xFFFFFFFF -> res_data=0xFFFFFFFE00000001.
//  3. Slave delays wready 3 cycles after awready; res_ready held low 5 cycles
//     -> correct product, wvalid held until handshake, res_data stable while held.
//  4. Slave returns bresp=1 on the B write -> no reads issued; res_err=1, res_data=0.
//  5. Slave never asserts rvalid, TIMEOUT=16 -> abort after 16 cycles in RD_LO; res_err=1;
//     the next operation succeeds.
//  6. Reset asserted during WR_B -> all valids 0 next cycle, IDLE, op_ready=1 after reset releases;
//     then two back-to-back ops complete in order.

Source files
------------

// File: rtl/mult_axi_master.sv
// AXI4-Lite master for the downstream multiplier slave.
// Accepts an operand pair, writes A then B, reads the 64-bit product back
// (low word first) and presents it on a result stream. One operation at a time.
module mult_axi_master #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          TIMEOUT    = 255
) (
  input  logic                      m2_axi_aclk,
  input  logic                      m2_axi_areset,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [DATA_WIDTH-1:0]     op_a,
  input  logic [DATA_WIDTH-1:0]     op_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [2*DATA_WIDTH-1:0]   res_data,
  output logic                      res_err,
  output logic [ADDR_WIDTH-1:0]     m2_axi_awaddr,
  output logic                      m2_axi_awvalid,
  input  logic                      m2_axi_awready,
  output logic [DATA_WIDTH-1:0]     m2_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m2_axi_wstrb,
  output logic                      m2_axi_wvalid,
  input  logic                      m2_axi_wready,
  input  logic                      m2_axi_bresp,
  input  logic                      m2_axi_bvalid,
  output logic                      m2_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m2_axi_araddr,
  output logic                      m2_axi_arvalid,
  input  logic                      m2_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m2_axi_rdata,
  input  logic                      m2_axi_rresp,
  input  logic                      m2_axi_rvalid,
  output logic                      m2_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_LO, RD_HI, DONE} state_t;

  // Slave register addresses, wrapped to the bus width
  localparam logic [ADDR_WIDTH-1:0] ADDR_A  = ADDR_WIDTH'(BASE_ADDR + 32'h0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_B  = ADDR_WIDTH'(BASE_ADDR + 32'h4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LO = ADDR_WIDTH'(BASE_ADDR + 32'h8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_HI = ADDR_WIDTH'(BASE_ADDR + 32'hC);
  // Last wait count a phase may reach before it is abandoned
  localparam logic [15:0]           WAIT_LAST = 16'(TIMEOUT - 1);

  state_t                    state_reg, state_next;
  logic [DATA_WIDTH-1:0]     b_reg, b_next;
  logic [ADDR_WIDTH-1:0]     awaddr_reg, awaddr_next;
  logic [ADDR_WIDTH-1:0]     araddr_reg, araddr_next;
  logic [DATA_WIDTH-1:0]     wdata_reg, wdata_next;
  logic                      awvalid_reg, awvalid_next;
  logic                      wvalid_reg, wvalid_next;
  logic                      aw_done_reg, aw_done_next;
  logic                      w_done_reg, w_done_next;
  logic                      bready_reg, bready_next;
  logic                      arvalid_reg, arvalid_next;
  logic                      rready_reg, rready_next;
  logic                      op_ready_reg, op_ready_next;
  logic                      res_valid_reg, res_valid_next;
  logic [2*DATA_WIDTH-1:0]   res_data_reg, res_data_next;
  logic                      res_err_reg, res_err_next;
  logic [15:0]               wait_cnt_reg, wait_cnt_next;
  logic                      step_done;
  logic                      fail;
  logic                      in_phase;

  // State and registered outputs; reset discards any in-flight operation
  always_ff @(posedge m2_axi_aclk) begin
    if (m2_axi_areset) begin
      state_reg     <= IDLE;
      b_reg         <= '0;
      awaddr_reg    <= '0;
      araddr_reg    <= '0;
      wdata_reg     <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      op_ready_reg  <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_err_reg   <= 1'b0;
      wait_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      b_reg         <= b_next;
      awaddr_reg    <= awaddr_next;
      araddr_reg    <= araddr_next;
      wdata_reg     <= wdata_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
      bready_reg    <= bready_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      op_ready_reg  <= op_ready_next;
      res_valid_reg <= res_valid_next;
      res_data_reg  <= res_data_next;
      res_err_reg   <= res_err_next;
      wait_cnt_reg  <= wait_cnt_next;
    end
  end

  // Next-state, channel handshakes, timeout and state-entry actions
  always_comb begin
    state_next    = state_reg;
    b_next        = b_reg;
    awaddr_next   = awaddr_reg;
    araddr_next   = araddr_reg;
    wdata_next    = wdata_reg;
    awvalid_next  = awvalid_reg;
    wvalid_next   = wvalid_reg;
    aw_done_next  = aw_done_reg;
    w_done_next   = w_done_reg;
    bready_next   = bready_reg;
    arvalid_next  = arvalid_reg;
    rready_next   = rready_reg;
    res_data_next = res_data_reg;
    res_err_next  = res_err_reg;
    wait_cnt_next = wait_cnt_reg;
    step_done     = 1'b0;
    fail          = 1'b0;
    in_phase      = (state_reg != IDLE) && (state_reg != DONE);

    case (state_reg)
      IDLE: begin
        if (op_valid && op_ready_reg) begin
          b_next        = op_b;
          wdata_next    = op_a;
          res_data_next = '0;
          res_err_next  = 1'b0;
          state_next    = WR_A;
        end
      end
      WR_A, WR_B: begin
        if (awvalid_reg && m2_axi_awready) begin
          awvalid_next = 1'b0;
          aw_done_next = 1'b1;
        end
        if (wvalid_reg && m2_axi_wready) begin
          wvalid_next = 1'b0;
          w_done_next = 1'b1;
        end
        // Open the response channel only once address and data are both taken
        if (!bready_reg && aw_done_next && w_done_next) begin
          bready_next = 1'b1;
        end
        if (bready_reg && m2_axi_bvalid) begin
          bready_next = 1'b0;
          step_done   = 1'b1;
          if (m2_axi_bresp) begin
            fail = 1'b1;
          end else begin
            state_next = (state_reg == WR_A) ? WR_B : RD_LO;
          end
        end
      end
      RD_LO, RD_HI: begin
        if (arvalid_reg && m2_axi_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
        end
        if (rready_reg && m2_axi_rvalid) begin
          rready_next = 1'b0;
          step_done   = 1'b1;
          if (m2_axi_rresp) begin
            fail = 1'b1;
          end else if (state_reg == RD_LO) begin
            res_data_next[DATA_WIDTH-1:0] = m2_axi_rdata;
            state_next                    = RD_HI;
          end else begin
            res_data_next[2*DATA_WIDTH-1:DATA_WIDTH] = m2_axi_rdata;
            state_next                               = DONE;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Every cycle a bus phase has not finished counts towards its timeout
    if (in_phase && !step_done) begin
      if (wait_cnt_reg >= WAIT_LAST) begin
        fail = 1'b1;
      end else begin
        wait_cnt_next = wait_cnt_reg + 16'd1;
      end
    end

    // Slave error or timeout: abandon the operation with a zeroed product
    if (fail) begin
      state_next    = DONE;
      res_err_next  = 1'b1;
      res_data_next = '0;
    end

    // Entering a state: clear all channel controls, then raise the ones it needs
    if (state_next != state_reg) begin
      wait_cnt_next = '0;
      aw_done_next  = 1'b0;
      w_done_next   = 1'b0;
      awvalid_next  = 1'b0;
      wvalid_next   = 1'b0;
      bready_next   = 1'b0;
      arvalid_next  = 1'b0;
      rready_next   = 1'b0;
      case (state_next)
        WR_A: begin
          awvalid_next = 1'b1;
          wvalid_next  = 1'b1;
          awaddr_next  = ADDR_A;
        end
        WR_B: begin
          awvalid_next = 1'b1;
          wvalid_next  = 1'b1;
          awaddr_next  = ADDR_B;
          wdata_next   = b_reg;
        end
        RD_LO: begin
          arvalid_next = 1'b1;
          araddr_next  = ADDR_LO;
        end
        RD_HI: begin
          arvalid_next = 1'b1;
          araddr_next  = ADDR_HI;
        end
        default: ;
      endcase
    end

    op_ready_next  = (state_next == IDLE);
    res_valid_next = (state_next == DONE);
  end

  assign op_ready       = op_ready_reg;
  assign res_valid      = res_valid_reg;
  assign res_data       = res_data_reg;
  assign res_err        = res_err_reg;
  assign m2_axi_awaddr  = awaddr_reg;
  assign m2_axi_awvalid = awvalid_reg;
  assign m2_axi_wdata   = wdata_reg;
  assign m2_axi_wstrb   = '1;
  assign m2_axi_wvalid  = wvalid_reg;
  assign m2_axi_bready  = bready_reg;
  assign m2_axi_araddr  = araddr_reg;
  assign m2_axi_arvalid = arvalid_reg;
  assign m2_axi_rready  = rready_reg;

endmodule

// File: tb/tb_mult_axi_master.sv
// Directed bench for mult_axi_master with a behavioural multiplier slave.
module tb_mult_axi_master;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic        res_err;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mult_axi_master #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8),
    .BASE_ADDR(0),
    .TIMEOUT(16)
  ) dut (
    .m2_axi_aclk   (clk),
    .m2_axi_areset (srst),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_err       (res_err),
    .m2_axi_awaddr (awaddr),
    .m2_axi_awvalid(awvalid),
    .m2_axi_awready(awready),
    .m2_axi_wdata  (wdata),
    .m2_axi_wstrb  (wstrb),
    .m2_axi_wvalid (wvalid),
    .m2_axi_wready (wready),
    .m2_axi_bresp  (bresp),
    .m2_axi_bvalid (bvalid),
    .m2_axi_bready (bready),
    .m2_axi_araddr (araddr),
    .m2_axi_arvalid(arvalid),
    .m2_axi_arready(arready),
    .m2_axi_rdata  (rdata),
    .m2_axi_rresp  (rresp),
    .m2_axi_rvalid (rvalid),
    .m2_axi_rready (rready)
  );

  // Slave knobs
  int   w_delay  = 0;
  logic b_err_en = 1'b0;
  logic r_mute   = 1'b0;

  // Slave state
  int          cyc = 0;
  int          aw_cyc = 0;
  logic        aw_got = 1'b0;
  logic        w_got = 1'b0;
  logic [7:0]  aw_addr_l = '0;
  logic [31:0] w_data_l = '0;
  logic [31:0] reg_a = '0;
  logic [31:0] reg_b = '0;
  logic [7:0]  wr_log[$];
  logic [7:0]  rd_log[$];

  wire        aw_hs = awvalid && awready;
  wire        w_hs  = wvalid && wready;
  wire        ar_hs = arvalid && arready;
  wire [7:0]  aw_addr_eff = aw_hs ? awaddr : aw_addr_l;
  wire [31:0] w_data_eff  = w_hs ? wdata : w_data_l;
  wire [63:0] product = {32'b0, reg_a} * {32'b0, reg_b};

  assign awready = 1'b1;
  assign arready = 1'b1;
  assign wready  = (w_delay == 0) || (aw_got && (cyc >= aw_cyc + w_delay));

  // Multiplier slave: responds one cycle after a complete write or a read address
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (srst) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      bvalid <= 1'b0;
      bresp  <= 1'b0;
      rvalid <= 1'b0;
      rresp  <= 1'b0;
      rdata  <= '0;
    end else begin
      if (aw_hs) begin
        aw_addr_l <= awaddr;
        aw_cyc    <= cyc;
      end
      if (w_hs) w_data_l <= wdata;
      if (bvalid && bready) bvalid <= 1'b0;
      if ((aw_hs || aw_got) && (w_hs || w_got)) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        bvalid <= 1'b1;
        bresp  <= b_err_en && (aw_addr_eff == 8'h04);
        if (aw_addr_eff == 8'h00) reg_a <= w_data_eff;
        else if (aw_addr_eff == 8'h04) reg_b <= w_data_eff;
        wr_log.push_back(aw_addr_eff);
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (ar_hs) begin
        rd_log.push_back(araddr);
        if (!r_mute) begin
          rvalid <= 1'b1;
          rresp  <= 1'b0;
          rdata  <= (araddr == 8'h08) ? product[31:0] : product[63:32];
        end
      end
    end
  end

  // Protocol monitor: valids held until handshake, never AW and AR together
  int   viol = 0;
  logic aw_pend = 1'b0;
  logic w_pend = 1'b0;
  always @(negedge clk) begin
    if (srst) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      if ((awvalid && arvalid) || (aw_pend && !awvalid) || (w_pend && !wvalid)) begin
        viol <= viol + 1;
      end
      aw_pend <= awvalid && !awready;
      w_pend  <= wvalid && !wready;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full operation; called at a negedge, returns at a negedge
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                        output logic [63:0] data, output logic err, output int lat,
                        output int unstable);
    int waitc;
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    waitc = 0;
    while (!op_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("op_ready_before_op", 64'(op_ready), 64'd1);
    @(negedge clk);
    op_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    data = res_data;
    err = res_err;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (res_data !== data || res_err !== err || !res_valid) unstable++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    $display("op a=0x%08h b=0x%08h -> res=0x%016h err=%0d latency=%0d", a, b, data, err, lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic        e;
    int          lat;
    int          uns;
    int          wb;
    int          rb;
    int          waitc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_handshakes", 64'({op_ready, res_valid, awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_res_err", 64'(res_err), 64'd0);
    check("rst_addr_data", 64'({awaddr, araddr, wdata}), 64'd0);
    check("rst_wstrb", 64'(wstrb), 64'hF);
    srst = 1'b0;
    @(negedge clk);
    check("op_ready_after_rst", 64'(op_ready), 64'd1);

    // 1: basic product, address sequence, latency
    wb = wr_log.size();
    rb = rd_log.size();
    run_op(32'h278, 32'h1468, 0, d, e, lat, uns);
    check("t1_data", d, 64'h00000000003260C0);
    check("t1_err", 64'(e), 64'd0);
    check("t1_latency", 64'(lat), 64'd9);
    check("t1_writes", 64'(wr_log.size() - wb), 64'd2);
    check("t1_reads", 64'(rd_log.size() - rb), 64'd2);
    if (wr_log.size() >= wb + 2 && rd_log.size() >= rb + 2) begin
      check("t1_wr_addrs", 64'({wr_log[wb], wr_log[wb+1]}), 64'h0004);
      check("t1_rd_addrs", 64'({rd_log[rb], rd_log[rb+1]}), 64'h080C);
    end
    check("t1_slave_a", 64'(reg_a), 64'h278);
    check("t1_op_ready_next", 64'(op_ready), 64'd1);

    // 2: all-ones operands
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, d, e, lat, uns);
    check("t2_data", d, 64'hFFFFFFFE00000001);
    check("t2_err", 64'(e), 64'd0);

    // 3: delayed wready and held result
    w_delay = 3;
    run_op(32'h00010000, 32'h00030000, 5, d, e, lat, uns);
    w_delay = 0;
    check("t3_data", d, 64'h0000000300000000);
    check("t3_err", 64'(e), 64'd0);
    check("t3_latency", 64'(lat), 64'd15);
    check("t3_stable", 64'(uns), 64'd0);
    check("t3_protocol", 64'(viol), 64'd0);

    // 4: error response on the B write
    b_err_en = 1'b1;
    rb = rd_log.size();
    run_op(32'h5, 32'h6, 0, d, e, lat, uns);
    b_err_en = 1'b0;
    check("t4_err", 64'(e), 64'd1);
    check("t4_data", d, 64'd0);
    check("t4_no_reads", 64'(rd_log.size() - rb), 64'd0);
    check("t4_latency", 64'(lat), 64'd5);

    // 5: read data never returned -> timeout, then a clean operation
    r_mute = 1'b1;
    run_op(32'h9, 32'h9, 0, d, e, lat, uns);
    r_mute = 1'b0;
    check("t5_err", 64'(e), 64'd1);
    check("t5_data", d, 64'd0);
    check("t5_latency", 64'(lat), 64'd21);
    run_op(32'h7, 32'h6, 0, d, e, lat, uns);
    check("t5_next_data", d, 64'h2A);
    check("t5_next_err", 64'(e), 64'd0);

    // 6: reset during WR_B
    op_a = 32'h11;
    op_b = 32'h22;
    op_valid = 1'b1;
    waitc = 0;
    @(negedge clk);
    op_valid = 1'b0;
    while (!(awvalid && awaddr == 8'h04) && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("t6_reached_wr_b", 64'(awvalid && awaddr == 8'h04), 64'd1);
    srst = 1'b1;
    @(negedge clk);
    check("t6_rst_handshakes", 64'({op_ready, res_valid, awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    srst = 1'b0;
    @(negedge clk);
    check("t6_op_ready", 64'(op_ready), 64'd1);
    check("t6_idle_bus", 64'({awvalid, wvalid, arvalid, res_valid}), 64'd0);
    run_op(32'h3, 32'h5, 0, d, e, lat, uns);
    check("t6_first_data", d, 64'hF);
    check("t6_back_to_back_ready", 64'(op_ready), 64'd1);
    run_op(32'h100, 32'h100, 0, d, e, lat, uns);
    check("t6_second_data", d, 64'h10000);
    check("t6_second_latency", 64'(lat), 64'd9);
    check("protocol_total", 64'(viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
